// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue_if
//  Description : Bundle of the fetch-queue handshake signals that run between
//                the fetch stage (push side), decode (pop side) and the
//                pipeline controller (flush / stall request).
//                slave  modport : seen by the queue itself
//                master modport : seen by whoever drives push/pop/flush
//  Ports       : push_i/inst_i/inst_addr_i/push_rdy_o  - fetch side
//                pop_i/inst_vld_o/inst_o/inst_addr_o   - decode side
//                flush_i/stallreq_o/count_o            - control / status
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_queue_if #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              push_i;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              push_rdy_o;
    logic              pop_i;
    logic              flush_i;
    logic              inst_vld_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [AW:0]       count_o;
    logic              stallreq_o;

    modport slave (
        input  push_i, inst_i, inst_addr_i, pop_i, flush_i,
        output push_rdy_o, inst_vld_o, inst_o, inst_addr_o, count_o, stallreq_o
    );

    modport master (
        output push_i, inst_i, inst_addr_i, pop_i, flush_i,
        input  push_rdy_o, inst_vld_o, inst_o, inst_addr_o, count_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Show-ahead fetch queue of {inst, pc} pairs between the ifu
//                and the idu. Decouples instruction fetch from decode stalls,
//                empties on flush and raises a fetch stall request when full.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                q      - inst_queue_if.slave (push/pop/flush handshake,
//                         head entry, occupancy, stall request)
//  Revision    : 1.0  initial release
// ============================================================================
module inst_queue #(
    parameter int              DEPTH  = 4,       // power of two, >= 2
    parameter int              INST_W = 32,
    parameter int              ADDR_W = 32,
    parameter logic [INST_W-1:0] NOP  = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);

    // Storage is intentionally not reset: pointers alone define validity.
    logic [INST_W+ADDR_W-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_push_acc;
    logic w_pop_acc;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                        (r_wr_ptr[AW] != r_rd_ptr[AW]);
    // Acceptance depends only on registered state, so push_rdy_o never has a
    // combinational path from pop_i: a push into a full queue is refused even
    // when a pop happens in the same cycle.
    assign w_push_acc = q.push_i && !w_full;
    assign w_pop_acc  = q.pop_i  && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (q.flush_i) begin
            // Flush drops everything still queued; same-cycle push/pop lost.
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc && !q.flush_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {q.inst_i, q.inst_addr_i};
        end
    end

    // Show-ahead head read; idle values keep decode seeing a harmless NOP.
    logic [INST_W+ADDR_W-1:0] w_head;
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign q.inst_vld_o  = !w_empty;
    assign q.inst_o      = w_empty ? NOP : w_head[INST_W+ADDR_W-1:ADDR_W];
    assign q.inst_addr_o = w_empty ? '0  : w_head[ADDR_W-1:0];
    assign q.count_o     = r_wr_ptr - r_rd_ptr;
    assign q.push_rdy_o  = !w_full;
    assign q.stallreq_o  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Self-checking bench for inst_queue. A queue-based reference
//                model tracks the expected contents; a compare process checks
//                every output on each falling edge, and directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_queue;
    localparam int DEPTH  = 4;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] BASE = 32'h80000000;

    logic clk;
    logic rst_n;

    inst_queue_if #(.DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

    inst_queue #(
        .DEPTH (DEPTH),
        .INST_W(INST_W),
        .ADDR_W(ADDR_W),
        .NOP   (NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .q    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction tied to its pc so each entry is unique; BASE maps to 0x00100093.
    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'h00100093 ^ BASE;
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] mq[$];   // {inst, pc}, index 0 is the oldest

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (bus.flush_i) begin
            mq.delete();
        end else begin
            bit can_push;
            bit can_pop;
            can_push = bus.push_i && (mq.size() < DEPTH);
            can_pop  = bus.pop_i  && (mq.size() > 0);
            if (can_pop)  void'(mq.pop_front());
            if (can_push) mq.push_back({bus.inst_i, bus.inst_addr_i});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        check("vld",   64'(bus.inst_vld_o),  64'(sz != 0));
        check("inst",  64'(bus.inst_o),      (sz != 0) ? 64'(mq[0][63:32]) : 64'(NOP));
        check("addr",  64'(bus.inst_addr_o), (sz != 0) ? 64'(mq[0][31:0])  : 64'd0);
        check("count", 64'(bus.count_o),     64'(sz));
        check("rdy",   64'(bus.push_rdy_o),  64'(sz < DEPTH));
        check("stall", 64'(bus.stallreq_o),  64'(sz == DEPTH));
    end

    // Drive one cycle of inputs from a falling edge, return at the next one.
    task automatic step(input logic push, input logic [31:0] pc, input logic pop, input logic flush);
        bus.push_i      = push;
        bus.inst_addr_i = pc;
        bus.inst_i      = mk_inst(pc);
        bus.pop_i       = pop;
        bus.flush_i     = flush;
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.push_i      = 1'b0;
        bus.inst_i      = '0;
        bus.inst_addr_i = '0;
        bus.pop_i       = 1'b0;
        bus.flush_i     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_vld",   64'(bus.inst_vld_o),  64'd0);
        check("rst_inst",  64'(bus.inst_o),      64'h13);
        check("rst_count", 64'(bus.count_o),     64'd0);
        check("rst_rdy",   64'(bus.push_rdy_o),  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single push appears one cycle later
        step(1'b1, BASE, 1'b0, 1'b0);
        check("t1_vld",   64'(bus.inst_vld_o),  64'd1);
        check("t1_addr",  64'(bus.inst_addr_o), 64'h80000000);
        check("t1_inst",  64'(bus.inst_o),      64'h00100093);
        check("t1_count", 64'(bus.count_o),     64'd1);

        // 2: fill to 4, fifth push ignored
        for (int i = 1; i < 4; i++) step(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0);
        check("t2_stall", 64'(bus.stallreq_o), 64'd1);
        check("t2_rdy",   64'(bus.push_rdy_o), 64'd0);
        step(1'b1, BASE + 32'h10, 1'b0, 1'b0);
        check("t2_count", 64'(bus.count_o),     64'd4);
        check("t2_head",  64'(bus.inst_addr_o), 64'h80000000);

        // 3: full, push+pop -> only pop taken
        step(1'b1, BASE + 32'h10, 1'b1, 1'b0);
        check("t3_count", 64'(bus.count_o),     64'd3);
        check("t3_head",  64'(bus.inst_addr_o), 64'h80000004);

        // 5: flush at count 3 with a push pending
        step(1'b1, BASE + 32'h20, 1'b0, 1'b1);
        check("t5_count", 64'(bus.count_o),    64'd0);
        check("t5_vld",   64'(bus.inst_vld_o), 64'd0);
        check("t5_inst",  64'(bus.inst_o),     64'h13);
        // pop while empty is ignored
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("empty_pop_count", 64'(bus.count_o), 64'd0);

        // 4: steady push+pop from count 2 across pointer wrap
        step(1'b1, BASE,        1'b0, 1'b0);
        step(1'b1, BASE + 32'h4, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, BASE + 32'(8 + 4 * k), 1'b1, 1'b0);
            check("t4_count", 64'(bus.count_o),     64'd2);
            check("t4_head",  64'(bus.inst_addr_o), 64'(BASE + 32'(4 * (k + 1))));
        end
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;

        // 6: asynchronous reset with 2 entries, checked before next rising edge
        check("t6_pre_count", 64'(bus.count_o), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_vld",   64'(bus.inst_vld_o),  64'd0);
        check("t6_count", 64'(bus.count_o),     64'd0);
        check("t6_inst",  64'(bus.inst_o),      64'h13);
        check("t6_addr",  64'(bus.inst_addr_o), 64'd0);
        check("t6_rdy",   64'(bus.push_rdy_o),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, BASE + 32'h40, 1'b0, 1'b0);
        check("post_rst_head", 64'(bus.inst_addr_o), 64'h80000040);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
